mem_req_arbiter_rr: RTL and testbench

- N-client round-robin arbiter onto the single L1-to-memory port, used by the core wrapper to share memory between L1D, L1I and future clients (page walker, prefetcher).
- Generalises the two-client, one-outstanding arbiter to N_REQ clients with a valid/ready downstream handshake.
- Supports up to MAX_OUT in-order outstanding transactions and routes responses back by a grant-order FIFO.

---
 rtl/mem_req_arbiter_rr_if.sv | 58 +++++
 rtl/mem_req_arbiter_rr.sv | 193 +++++++++++++++++++
 tb/tb_mem_req_arbiter_rr.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_arbiter_rr_if.sv
// ---------------------------------------------------------------------------
// mem_req_arbiter_rr_if
//
// Purpose: bundles the single shared L1-to-memory port. The request half
// (valid/ready handshake plus the granted address, store line, tag and
// opcode) flows from the arbiter to memory. The response half (in-order
// strobe plus load line) flows back.
//
// Signals:
//   mem_req_valid       arbiter -> memory   request valid (registered in arbiter)
//   mem_req_ready       memory  -> arbiter  request accepted when valid && ready
//   mem_req_addr        arbiter -> memory   granted address
//   mem_req_store_data  arbiter -> memory   granted store line
//   mem_req_tag         arbiter -> memory   granted tag (opaque)
//   mem_req_opcode      arbiter -> memory   granted opcode (opaque)
//   mem_rsp_valid       memory  -> arbiter  in-order response strobe
//   mem_rsp_load_data   memory  -> arbiter  response line
//
// Modports:
//   master : the arbiter side
//   slave  : the memory side
// ---------------------------------------------------------------------------
interface mem_req_arbiter_rr_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128,
    parameter int TAG_W  = 4
);
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_store_data;
    logic [TAG_W-1:0]  mem_req_tag;
    logic [3:0]        mem_req_opcode;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_load_data;

    modport master (
        output mem_req_valid,
        output mem_req_addr,
        output mem_req_store_data,
        output mem_req_tag,
        output mem_req_opcode,
        input  mem_req_ready,
        input  mem_rsp_valid,
        input  mem_rsp_load_data
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        input  mem_req_store_data,
        input  mem_req_tag,
        input  mem_req_opcode,
        output mem_req_ready,
        output mem_rsp_valid,
        output mem_rsp_load_data
    );
endinterface

// File: rtl/mem_req_arbiter_rr.sv
// ---------------------------------------------------------------------------
// mem_req_arbiter_rr
//
// Purpose: round-robin arbiter that shares the single memory port between
// N_REQ clients (L1D, L1I, later a page walker and prefetcher). Each client
// may hold at most one transaction. Up to MAX_OUT granted-but-unanswered
// transactions may be in flight. Memory answers strictly in order, so a
// FIFO of granted client ids steers each response back to its owner.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   req_valid[N_REQ]    one-cycle request pulse per client
//   req_addr            client i at [i*ADDR_W +: ADDR_W], stable until its response
//   req_store_data      client i at [i*DATA_W +: DATA_W], same stability
//   req_tag             client i at [i*TAG_W  +: TAG_W],  same stability
//   req_opcode          client i at [i*4 +: 4],          same stability
//   mem                 shared memory port (master modport)
//   rsp_valid[N_REQ]    one-hot response strobe for the owning client
//   rsp_load_data       response line broadcast to every client
//   outstanding         granted-but-unanswered transaction count
//   proto_err           sticky flag for client or memory protocol violations
// ---------------------------------------------------------------------------
module mem_req_arbiter_rr #(
    parameter int N_REQ   = 3,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 128,
    parameter int TAG_W   = 4,
    parameter int MAX_OUT = 2,
    localparam int ID_W   = $clog2(N_REQ),
    localparam int CNT_W  = $clog2(MAX_OUT + 1),
    localparam int FP_W   = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_store_data,
    input  logic [N_REQ*TAG_W-1:0]    req_tag,
    input  logic [N_REQ*4-1:0]        req_opcode,
    mem_req_arbiter_rr_if.master      mem,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]         rsp_load_data,
    output logic [CNT_W-1:0]          outstanding,
    output logic                      proto_err
);

    // Per-client bookkeeping: pending = requested but not yet granted,
    // busy = granted and waiting for its response (its id sits in the FIFO).
    logic [N_REQ-1:0]  pending_q, pending_d;
    logic [N_REQ-1:0]  busy_q, busy_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;

    // Grant-order FIFO of client ids.
    logic [ID_W-1:0]   fifo_q [MAX_OUT];
    logic [ID_W-1:0]   fifo_d [MAX_OUT];
    logic [FP_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FP_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Registered downstream request.
    logic              mem_req_valid_q, mem_req_valid_d;
    logic [ADDR_W-1:0] mem_req_addr_q, mem_req_addr_d;
    logic [DATA_W-1:0] mem_req_store_data_q, mem_req_store_data_d;
    logic [TAG_W-1:0]  mem_req_tag_q, mem_req_tag_d;
    logic [3:0]        mem_req_opcode_q, mem_req_opcode_d;

    logic              proto_err_q, proto_err_d;

    // Combinational helpers.
    logic [N_REQ-1:0]  n_pending;
    logic              req_err;
    logic              rsp_err;
    logic              pop;
    logic              slot_free;
    logic              credit_ok;
    logic              win_found;
    logic [ID_W-1:0]   win_id;
    logic              grant;
    logic [ID_W-1:0]   head_id;

    function automatic logic [FP_W-1:0] fp_next(input logic [FP_W-1:0] p);
        fp_next = (int'(p) == MAX_OUT - 1) ? '0 : FP_W'(int'(p) + 1);
    endfunction

    assign head_id = fifo_q[rd_ptr_q];

    // Arbitration and next-state logic. A pulse from a client that is still
    // pending or busy is dropped and flagged. A response popping client i in
    // the same cycle as a fresh pulse from i is therefore also a violation,
    // because busy_q is still set. The credit check allows a pop in this cycle
    // to free a slot for a grant in the same cycle.
    always_comb begin
        n_pending            = pending_q | (req_valid & ~busy_q);
        req_err              = |(req_valid & (pending_q | busy_q));
        pop                  = mem.mem_rsp_valid && (count_q != '0);
        rsp_err              = mem.mem_rsp_valid && (count_q == '0);
        slot_free            = !mem_req_valid_q || mem.mem_req_ready;
        credit_ok            = (int'(count_q) - int'(pop)) < MAX_OUT;

        win_found            = 1'b0;
        win_id               = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!win_found && n_pending[(int'(rr_ptr_q) + k) % N_REQ]) begin
                win_found = 1'b1;
                win_id    = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
            end
        end
        grant                = slot_free && credit_ok && win_found;

        pending_d            = n_pending;
        busy_d               = busy_q;
        rr_ptr_d             = rr_ptr_q;
        fifo_d               = fifo_q;
        wr_ptr_d             = wr_ptr_q;
        rd_ptr_d             = rd_ptr_q;
        count_d              = CNT_W'(int'(count_q) + int'(grant) - int'(pop));
        mem_req_valid_d      = mem_req_valid_q;
        mem_req_addr_d       = mem_req_addr_q;
        mem_req_store_data_d = mem_req_store_data_q;
        mem_req_tag_d        = mem_req_tag_q;
        mem_req_opcode_d     = mem_req_opcode_q;
        proto_err_d          = proto_err_q | req_err | rsp_err;

        if (pop) begin
            busy_d[head_id] = 1'b0;
            rd_ptr_d        = fp_next(rd_ptr_q);
        end

        // A granted client cannot also be the one being popped (it was not
        // busy), so the order of these updates does not matter.
        if (grant) begin
            pending_d[win_id]    = 1'b0;
            busy_d[win_id]       = 1'b1;
            rr_ptr_d             = (int'(win_id) == N_REQ - 1) ? '0 : win_id + 1'b1;
            fifo_d[wr_ptr_q]     = win_id;
            wr_ptr_d             = fp_next(wr_ptr_q);
            mem_req_valid_d      = 1'b1;
            mem_req_addr_d       = req_addr[int'(win_id)*ADDR_W +: ADDR_W];
            mem_req_store_data_d = req_store_data[int'(win_id)*DATA_W +: DATA_W];
            mem_req_tag_d        = req_tag[int'(win_id)*TAG_W +: TAG_W];
            mem_req_opcode_d     = req_opcode[int'(win_id)*4 +: 4];
        end else if (slot_free) begin
            mem_req_valid_d      = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q            <= '0;
            busy_q               <= '0;
            rr_ptr_q             <= '0;
            for (int i = 0; i < MAX_OUT; i++) fifo_q[i] <= '0;
            wr_ptr_q             <= '0;
            rd_ptr_q             <= '0;
            count_q              <= '0;
            mem_req_valid_q      <= 1'b0;
            mem_req_addr_q       <= '0;
            mem_req_store_data_q <= '0;
            mem_req_tag_q        <= '0;
            mem_req_opcode_q     <= '0;
            proto_err_q          <= 1'b0;
        end else begin
            pending_q            <= pending_d;
            busy_q               <= busy_d;
            rr_ptr_q             <= rr_ptr_d;
            fifo_q               <= fifo_d;
            wr_ptr_q             <= wr_ptr_d;
            rd_ptr_q             <= rd_ptr_d;
            count_q              <= count_d;
            mem_req_valid_q      <= mem_req_valid_d;
            mem_req_addr_q       <= mem_req_addr_d;
            mem_req_store_data_q <= mem_req_store_data_d;
            mem_req_tag_q        <= mem_req_tag_d;
            mem_req_opcode_q     <= mem_req_opcode_d;
            proto_err_q          <= proto_err_d;
        end
    end

    assign mem.mem_req_valid      = mem_req_valid_q;
    assign mem.mem_req_addr       = mem_req_addr_q;
    assign mem.mem_req_store_data = mem_req_store_data_q;
    assign mem.mem_req_tag        = mem_req_tag_q;
    assign mem.mem_req_opcode     = mem_req_opcode_q;

    // Response steering: the FIFO head owns the current response. A strobe
    // with an empty FIFO is dropped here and flagged through rsp_err.
    assign rsp_valid     = pop ? (N_REQ'(1) << head_id) : '0;
    assign rsp_load_data = mem.mem_rsp_load_data;
    assign outstanding   = count_q;
    assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_mem_req_arbiter_rr.sv
// ---------------------------------------------------------------------------
// tb_mem_req_arbiter_rr
//
// Purpose: self-checking bench for mem_req_arbiter_rr (N_REQ=3, MAX_OUT=2).
// A behavioural model holds the FIFO as a queue of client ids and derives
// every output from the arbitration rules. Directed scenarios (single
// client, round-robin, backpressure, credit limit, in-order routing,
// protocol errors, reset) are followed by a randomized legal-traffic phase.
// ---------------------------------------------------------------------------
module tb_mem_req_arbiter_rr;

    localparam int N_REQ   = 3;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 128;
    localparam int TAG_W   = 4;
    localparam int MAX_OUT = 2;
    localparam int CNT_W   = $clog2(MAX_OUT + 1);

    logic                    clk;
    logic                    reset;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_store_data;
    logic [N_REQ*TAG_W-1:0]  req_tag;
    logic [N_REQ*4-1:0]      req_opcode;
    logic [N_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]       rsp_load_data;
    logic [CNT_W-1:0]        outstanding;
    logic                    proto_err;

    mem_req_arbiter_rr_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) mem_if ();

    mem_req_arbiter_rr #(
        .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_store_data (req_store_data),
        .req_tag        (req_tag),
        .req_opcode     (req_opcode),
        .mem            (mem_if),
        .rsp_valid      (rsp_valid),
        .rsp_load_data  (rsp_load_data),
        .outstanding    (outstanding),
        .proto_err      (proto_err)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int assert_count = 0;
    int fail_count   = 0;

    // Per-client request fields as the clients present them.
    logic [ADDR_W-1:0] c_addr [N_REQ];
    logic [DATA_W-1:0] c_data [N_REQ];
    logic [TAG_W-1:0]  c_tag  [N_REQ];
    logic [3:0]        c_op   [N_REQ];

    // Reference model state.
    bit [N_REQ-1:0]    m_pend;
    int                m_rr;
    int                m_fifo [$];
    bit                m_valid;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    logic [TAG_W-1:0]  m_tag;
    logic [3:0]        m_op;
    bit                m_perr;
    int                m_acc;

    logic [N_REQ-1:0]  rnd_rv;
    logic              rnd_rdy;
    logic              rnd_rspv;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [DATA_W-1:0] obs,
                               input logic [DATA_W-1:0] exp);
        assert_count++;
        if (obs !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit inFifo(input int id);
        inFifo = 1'b0;
        foreach (m_fifo[j]) if (m_fifo[j] == id) inFifo = 1'b1;
    endfunction

    function automatic bit clientIdle(input int id);
        clientIdle = !m_pend[id] && !inFifo(id);
    endfunction

    task automatic modelReset();
        m_pend  = '0;
        m_rr    = 0;
        m_fifo.delete();
        m_valid = 1'b0;
        m_addr  = '0;
        m_data  = '0;
        m_tag   = '0;
        m_op    = '0;
        m_perr  = 1'b0;
        m_acc   = 0;
    endtask

    // Advance the model by one clock using the inputs that the coming edge sees.
    task automatic modelStep(input logic [N_REQ-1:0] rv, input logic rdy, input logic rspv);
        bit [N_REQ-1:0] npend;
        bit             pop;
        bit             slot_free;
        bit             grant;
        int             win;
        int             in_flight;
        pop = rspv && (m_fifo.size() > 0);
        if (rspv && m_fifo.size() == 0) m_perr = 1'b1;
        for (int i = 0; i < N_REQ; i++) begin
            bit busy;
            busy = inFifo(i);
            if (rv[i] && (m_pend[i] || busy)) m_perr = 1'b1;
            npend[i] = m_pend[i] || (rv[i] && !busy);
        end
        slot_free = !m_valid || rdy;
        in_flight = m_fifo.size() - (pop ? 1 : 0);
        grant = 1'b0;
        win   = 0;
        if (slot_free && in_flight < MAX_OUT) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!grant && npend[(m_rr + k) % N_REQ]) begin
                    grant = 1'b1;
                    win   = (m_rr + k) % N_REQ;
                end
            end
        end
        if (m_valid && rdy) m_acc++;
        if (pop) begin
            m_fifo.delete(0);
            if (m_acc > 0) m_acc--;
        end
        if (grant) begin
            m_fifo.push_back(win);
            npend[win] = 1'b0;
            m_rr    = (win + 1) % N_REQ;
            m_valid = 1'b1;
            m_addr  = c_addr[win];
            m_data  = c_data[win];
            m_tag   = c_tag[win];
            m_op    = c_op[win];
        end else if (slot_free) begin
            m_valid = 1'b0;
        end
        m_pend = npend;
    endtask

    task automatic checkAll(input logic rspv, input logic [DATA_W-1:0] rdata);
        logic [N_REQ-1:0] exp_rsp;
        exp_rsp = '0;
        if (rspv && m_fifo.size() > 0) exp_rsp[m_fifo[0]] = 1'b1;
        checkOutput("mem_req_valid", DATA_W'(mem_if.mem_req_valid), DATA_W'(m_valid));
        checkOutput("outstanding", DATA_W'(outstanding), DATA_W'(m_fifo.size()));
        checkOutput("rsp_valid", DATA_W'(rsp_valid), DATA_W'(exp_rsp));
        checkOutput("rsp_load_data", rsp_load_data, rdata);
        checkOutput("proto_err", DATA_W'(proto_err), DATA_W'(m_perr));
        if (m_valid) begin
            checkOutput("mem_req_addr", DATA_W'(mem_if.mem_req_addr), DATA_W'(m_addr));
            checkOutput("mem_req_store_data", mem_if.mem_req_store_data, m_data);
            checkOutput("mem_req_tag", DATA_W'(mem_if.mem_req_tag), DATA_W'(m_tag));
            checkOutput("mem_req_opcode", DATA_W'(mem_if.mem_req_opcode), DATA_W'(m_op));
        end
    endtask

    // One cycle: drive inputs just after a falling edge, check outputs 1 time
    // unit later, update the model, then wait for the next falling edge.
    task automatic applyStimulus(input logic [N_REQ-1:0] rv, input logic rdy,
                                 input logic rspv, input logic [DATA_W-1:0] rdata);
        for (int i = 0; i < N_REQ; i++) begin
            req_addr[i*ADDR_W +: ADDR_W]       = c_addr[i];
            req_store_data[i*DATA_W +: DATA_W] = c_data[i];
            req_tag[i*TAG_W +: TAG_W]          = c_tag[i];
            req_opcode[i*4 +: 4]               = c_op[i];
        end
        req_valid                = rv;
        mem_if.mem_req_ready     = rdy;
        mem_if.mem_rsp_valid     = rspv;
        mem_if.mem_rsp_load_data = rdata;
        #1;
        checkAll(rspv, rdata);
        modelStep(rv, rdy, rspv);
        @(negedge clk);
    endtask

    function automatic logic [DATA_W-1:0] rndLine();
        rndLine = {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic setClient(input int id, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d, input logic [TAG_W-1:0] t,
                             input logic [3:0] op);
        c_addr[id] = a;
        c_data[id] = d;
        c_tag[id]  = t;
        c_op[id]   = op;
    endtask

    // Memory with ready held high, answering only accepted requests.
    task automatic drain(input int cycles);
        for (int n = 0; n < cycles; n++) applyStimulus('0, 1'b1, m_acc > 0, rndLine());
    endtask

    // Reset for one edge, then confirm every output is back at its reset value.
    task automatic resetDut();
        reset                    = 1'b1;
        req_valid                = '0;
        mem_if.mem_req_ready     = 1'b0;
        mem_if.mem_rsp_valid     = 1'b0;
        mem_if.mem_rsp_load_data = '0;
        @(negedge clk);
        #1;
        checkOutput("rst_mem_req_valid", DATA_W'(mem_if.mem_req_valid), '0);
        checkOutput("rst_mem_req_addr", DATA_W'(mem_if.mem_req_addr), '0);
        checkOutput("rst_mem_req_store_data", mem_if.mem_req_store_data, '0);
        checkOutput("rst_mem_req_tag", DATA_W'(mem_if.mem_req_tag), '0);
        checkOutput("rst_mem_req_opcode", DATA_W'(mem_if.mem_req_opcode), '0);
        checkOutput("rst_rsp_valid", DATA_W'(rsp_valid), '0);
        checkOutput("rst_outstanding", DATA_W'(outstanding), '0);
        checkOutput("rst_proto_err", DATA_W'(proto_err), '0);
        modelReset();
        reset = 1'b0;
    endtask

    // Guard against a hung simulation.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < N_REQ; i++) setClient(i, '0, '0, '0, '0);
        req_addr = '0; req_store_data = '0; req_tag = '0; req_opcode = '0;
        resetDut();

        $display("[TB] single client");
        applyStimulus('0, 1'b1, 1'b0, '0);
        setClient(1, 32'h0000_1000, {4{32'hCAFE_0001}}, 4'd3, 4'h2);
        applyStimulus(3'b010, 1'b1, 1'b0, '0);
        applyStimulus('0, 1'b1, 1'b0, '0);
        applyStimulus('0, 1'b1, 1'b0, '0);
        applyStimulus('0, 1'b1, 1'b0, '0);
        applyStimulus('0, 1'b1, 1'b1, {16{8'h55}});
        applyStimulus('0, 1'b1, 1'b0, '0);

        $display("[TB] round-robin with all clients");
        setClient(0, 32'h0000_2000, {4{32'h1111_0000}}, 4'd0, 4'h1);
        setClient(1, 32'h0000_2100, {4{32'h2222_0000}}, 4'd1, 4'h3);
        setClient(2, 32'h0000_2200, {4{32'h3333_0000}}, 4'd2, 4'h5);
        applyStimulus(3'b111, 1'b1, 1'b0, '0);
        applyStimulus('0, 1'b1, 1'b0, '0);
        applyStimulus('0, 1'b1, 1'b0, '0);
        drain(10);

        $display("[TB] backpressure");
        setClient(0, 32'h0000_3000, {4{32'h4444_0000}}, 4'd5, 4'h7);
        setClient(2, 32'h0000_3200, {4{32'h5555_0000}}, 4'd6, 4'h8);
        applyStimulus(3'b101, 1'b0, 1'b0, '0);
        for (int n = 0; n < 4; n++) applyStimulus('0, 1'b0, 1'b0, '0);
        applyStimulus('0, 1'b1, 1'b0, '0);
        drain(10);

        $display("[TB] credit limit and in-order routing");
        setClient(0, 32'h0000_4000, {16{8'hA0}}, 4'd7, 4'h0);
        setClient(1, 32'h0000_4100, {16{8'hB1}}, 4'd8, 4'h1);
        setClient(2, 32'h0000_4200, {16{8'hC2}}, 4'd9, 4'h2);
        applyStimulus(3'b111, 1'b1, 1'b0, '0);
        for (int n = 0; n < 3; n++) applyStimulus('0, 1'b1, 1'b0, '0);
        applyStimulus('0, 1'b1, 1'b1, {16{8'hAA}});
        applyStimulus('0, 1'b1, 1'b0, '0);
        applyStimulus('0, 1'b1, 1'b1, {16{8'hBB}});
        drain(8);

        $display("[TB] randomized legal traffic");
        for (int cyc = 0; cyc < 500; cyc++) begin
            rnd_rv = '0;
            for (int i = 0; i < N_REQ; i++) begin
                if (clientIdle(i)) begin
                    setClient(i, $urandom(), rndLine(), TAG_W'($urandom()), 4'($urandom()));
                    if ($urandom_range(0, 2) == 0) rnd_rv[i] = 1'b1;
                end
            end
            rnd_rdy  = ($urandom_range(0, 3) != 0);
            rnd_rspv = (m_acc > 0) && ($urandom_range(0, 2) != 0);
            applyStimulus(rnd_rv, rnd_rdy, rnd_rspv, rndLine());
        end
        drain(12);

        $display("[TB] protocol errors and reset");
        applyStimulus('0, 1'b1, 1'b1, {16{8'hEE}});
        applyStimulus('0, 1'b1, 1'b0, '0);
        resetDut();
        setClient(0, 32'h0000_5000, {16{8'h50}}, 4'd1, 4'h4);
        applyStimulus(3'b001, 1'b1, 1'b0, '0);
        applyStimulus('0, 1'b1, 1'b0, '0);
        applyStimulus(3'b001, 1'b1, 1'b0, '0);
        applyStimulus('0, 1'b1, 1'b0, '0);
        setClient(1, 32'h0000_5100, {16{8'h51}}, 4'd2, 4'h6);
        applyStimulus(3'b010, 1'b1, 1'b0, '0);
        applyStimulus('0, 1'b1, 1'b0, '0);
        applyStimulus('0, 1'b1, 1'b0, '0);
        resetDut();
        applyStimulus('0, 1'b1, 1'b1, {16{8'h77}});
        applyStimulus('0, 1'b1, 1'b0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
